// File: rtl/apb_mem_pkg.sv
// Shared types and default widths for the APB memory slave.
package apb_mem_pkg;
  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;
  localparam int APB_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;
endpackage

// File: rtl/apb_mem_array.sv
// Word-addressed storage: one synchronous write port, one asynchronous read port.
module apb_mem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam logic [IDX_W:0] DEPTH_IDX = (IDX_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Guards only matter for non power-of-two depths, where low index bits can exceed DEPTH.
  always_ff @(posedge clk_i) begin
    if (we_i && ({1'b0, waddr_i} < DEPTH_IDX)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = ({1'b0, raddr_i} < DEPTH_IDX) ? mem_q[raddr_i] : '0;
endmodule

// File: rtl/apb_mem_slave.sv
// APB memory slave with programmable wait states.
// Optional APB_MEM_SLVERR_EN: out-of-range accesses return PSlvErr instead of wrapping.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              PSel,
  input  logic              PEnable,
  input  logic              PWrite,
  input  logic [ADDR_W-1:0] PAddr,
  input  logic [DATA_W-1:0] PWData,
  output logic [DATA_W-1:0] PRData,
  output logic              PReady,
  output logic              PSlvErr
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [APB_CNT_W-1:0] WS_L = APB_CNT_W'(WAIT_STATES);

  apb_state_e            state_q, state_d;
  logic [APB_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  write_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     prdata_q;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  load_rd;
  logic                  sample;

  logic [ADDR_W-1:0]     cur_addr;
  logic                  cur_write;
  logic                  cur_err;
  logic [IDX_W-1:0]      idx;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_we;

  // In SETUP the bus still carries the transfer, so zero-wait reads index memory from PAddr.
  assign cur_addr  = (state_q == SETUP) ? PAddr  : addr_q;
  assign cur_write = (state_q == SETUP) ? PWrite : write_q;
  assign idx       = cur_addr[IDX_W-1:0];

`ifdef APB_MEM_SLVERR_EN
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  assign cur_err = ({1'b0, cur_addr} >= DEPTH_EXT);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^cur_addr;
  assign cur_err        = 1'b0;
`endif

  assign mem_we = (state_q == ACCESS) && pready_q && write_q && !cur_err;

  apb_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (idx),
    .wdata_i (wdata_q),
    .raddr_i (idx),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    load_rd   = 1'b0;
    sample    = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSel && !PEnable) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = WS_L;
        sample  = 1'b1;
        if (WAIT_STATES == 0) begin
          pready_d  = 1'b1;
          pslverr_d = cur_err;
          load_rd   = !cur_write;
        end
      end
      ACCESS: begin
        if (pready_q) begin
          state_d = (PSel && !PEnable) ? SETUP : IDLE;
          cnt_d   = '0;
        end else if (!PSel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= APB_CNT_W'(1)) begin
          cnt_d     = '0;
          pready_d  = 1'b1;
          pslverr_d = cur_err;
          load_rd   = !cur_write;
        end else begin
          cnt_d = cnt_q - APB_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      if (sample) begin
        addr_q  <= PAddr;
        write_q <= PWrite;
        wdata_q <= PWData;
      end
      if (load_rd) prdata_q <= cur_err ? '0 : mem_rdata;
    end
  end

  assign PRData  = prdata_q;
  assign PReady  = pready_q;
  assign PSlvErr = pslverr_q;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench: three slaves (0, 2, 3 wait states) checked against an array model.
module tb_apb_mem_slave;
  localparam int N = 3;

  typedef struct {
    int          inst;
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic              clk;
  logic [N-1:0]      rst_n, psel, penable, pwrite;
  logic [15:0]       paddr  [N];
  logic [31:0]       pwdata [N];
  logic [31:0]       prdata [N];
  logic [N-1:0]      pready, pslverr;

  logic [31:0] ref_mem [N][256];
  logic [31:0] last_rd [N];
  exp_t        sbq [$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    apb_mem_slave #(
      .ADDR_W(16), .DATA_W(32), .DEPTH(256),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) dut (
      .clk     (clk),
      .Rst     (rst_n[g]),
      .PSel    (psel[g]),
      .PEnable (penable[g]),
      .PWrite  (pwrite[g]),
      .PAddr   (paddr[g]),
      .PWData  (pwdata[g]),
      .PRData  (prdata[g]),
      .PReady  (pready[g]),
      .PSlvErr (pslverr[g])
    );

    // Monitor: acc counts enabled cycles of the current transfer up to and including PReady.
    initial begin
      int   acc;
      logic prev;
      exp_t e;
      acc  = 0;
      prev = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n[g] || !psel[g]) acc = 0;
        else if (penable[g]) acc++;
        if (rst_n[g] && pready[g]) begin
          chk($sformatf("ready_one_cycle[%0d]", g), 32'(prev), 32'd0);
          if (sbq.size() == 0 || sbq[0].inst != g) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ready[%0d]: got PReady=1 want 0 (no transfer pending)", g);
          end else begin
            e = sbq.pop_front();
            chk($sformatf("latency[%0d]", g), 32'(acc), 32'(e.lat));
            chk($sformatf("prdata[%0d]", g), prdata[g], e.data);
            chk($sformatf("pslverr[%0d]", g), 32'(pslverr[g]), 32'(e.err));
          end
          acc = 0;
        end
        prev = pready[g];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Issue one transfer; caller is #1 after a rising edge, returns #1 after the completing edge.
  task automatic xfer(input int i, input logic wr, input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    int   idx;
    logic oor;
    logic got;
    oor = (a >= 16'd256);
    idx = int'(a) % 256;
    e.inst = i;
    e.rd   = !wr;
    e.lat  = ws_of(i) + 2;
`ifdef APB_MEM_SLVERR_EN
    e.err = oor;
`else
    e.err = 1'b0;
    oor   = 1'b0;
`endif
    if (wr) begin
      if (!oor) ref_mem[i][idx] = d;
    end else begin
      last_rd[i] = oor ? 32'd0 : ref_mem[i][idx];
    end
    e.data = last_rd[i];
    sbq.push_back(e);

    psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr; paddr[i] = a; pwdata[i] = d;
    @(posedge clk); #1 penable[i] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      got = pready[i];
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout[%0d]: PReady got 0 want 1 within 40 cycles", i);
      sbq.delete();
    end
    @(posedge clk); #1;
    psel[i] = 1'b0; penable[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation got no finish want finish by 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst_n = '0; psel = '0; penable = '0; pwrite = '0;
    for (int i = 0; i < N; i++) begin
      paddr[i] = '0; pwdata[i] = '0; last_rd[i] = '0;
    end
    #12;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_pready[%0d]", i), 32'(pready[i]), 32'd0);
      chk($sformatf("rst_pslverr[%0d]", i), 32'(pslverr[i]), 32'd0);
      chk($sformatf("rst_prdata[%0d]", i), prdata[i], 32'd0);
    end
    @(negedge clk) rst_n = '1;
    @(posedge clk); #1;

    for (int i = 0; i < N; i++)
      for (int a = 0; a < 256; a++) xfer(i, 1'b1, 16'(a), $urandom);

    // Zero-wait write/read, then a 2-wait read whose PReady must drop right after.
    xfer(0, 1'b1, 16'h0050, 32'h0000_0050);
    xfer(0, 1'b0, 16'h0050, 32'h0);
    xfer(1, 1'b0, 16'h0033, 32'h0);
    chk("ready_low_after[1]", 32'(pready[1]), 32'd0);

    xfer(0, 1'b1, 16'h0010, 32'hA5A5_A5A5);
    xfer(0, 1'b1, 16'h0011, 32'h5A5A_5A5A);
    xfer(0, 1'b0, 16'h0010, 32'h0);
    xfer(0, 1'b0, 16'h0011, 32'h0);

    xfer(0, 1'b1, 16'h0005, 32'h1111_1111);
    xfer(0, 1'b1, 16'h0105, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 16'h0005, 32'h0);
    xfer(0, 1'b0, 16'h0105, 32'h0);

    // Reset in the middle of a 3-wait write: nothing may commit.
    xfer(2, 1'b1, 16'h0020, 32'hCAFE_0001);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 16'h0020; pwdata[2] = 32'hBAD0_BAD0;
    @(posedge clk); #1 penable[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n[2] = 1'b0;
    #1;
    chk("rst_mid_pready", 32'(pready[2]), 32'd0);
    chk("rst_mid_prdata", prdata[2], 32'd0);
    last_rd[2] = 32'd0;
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(negedge clk) rst_n[2] = 1'b1;
    @(posedge clk); #1;
    xfer(2, 1'b0, 16'h0020, 32'h0);

    // PSel dropped during ACCESS before PReady: no write, PRData held.
    xfer(2, 1'b1, 16'h0030, 32'h0123_4567);
    xfer(2, 1'b0, 16'h0031, 32'h0);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 16'h0030; pwdata[2] = 32'hFFFF_0000;
    @(posedge clk); #1 penable[2] = 1'b1;
    @(posedge clk); #1 psel[2] = 1'b0; penable[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_prdata", prdata[2], last_rd[2]);
    chk("abort_pready", 32'(pready[2]), 32'd0);
    xfer(2, 1'b0, 16'h0030, 32'h0);

    // PSel+PEnable straight from IDLE is ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 16'h0040; pwdata[0] = 32'h7777_7777;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("violation_pready", 32'(pready[0]), 32'd0);
    end
    @(posedge clk); #1 psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b0, 16'h0040, 32'h0);

    for (int k = 0; k < 300; k++) begin
      int          i;
      logic [15:0] a;
      i = $urandom_range(0, N - 1);
      a = ($urandom_range(0, 9) < 7) ? 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 65535));
      v = $urandom;
      xfer(i, 1'($urandom_range(0, 1)), a, v);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 Parameter ADDR_W, default 16, PAddr width.
REQ-002 Parameter DATA_W, default 32, PWData/PRData width.
REQ-003 Parameter DEPTH, default 256, memory word count; must satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter WAIT_STATES, default 0, extra ACCESS cycles before PReady; range 0..15.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 Rst  input  1  asynchronous, active-low reset.
REQ-007 PSel  input  1  slave select.
REQ-008 PEnable  input  1  access phase.
REQ-009 PWrite  input  1  1 = write, 0 = read.
REQ-010 PAddr  input  ADDR_W  word address (memory[PAddr], no byte lanes).
REQ-011 PWData  input  DATA_W  write data.
REQ-012 PRData  output  DATA_W  read data, registered.
REQ-013 PReady  output  1  transfer complete, registered.
REQ-014 PSlvErr  output  1  transfer error, registered, meaningful only while PReady=1.

Function
REQ-015 FSM states IDLE, SETUP, ACCESS; a 4-bit wait counter is loaded with WAIT_STATES on entry to ACCESS.
REQ-016 IDLE->SETUP when PSel=1 and PEnable=0; PSel=1 with PEnable=1 in IDLE is a protocol violation: stay IDLE, PReady=0, no memory effect.
REQ-017 SETUP->ACCESS unconditionally on the next edge; PAddr/PWrite/PWData are sampled at the SETUP->ACCESS edge.
REQ-018 In ACCESS, the counter decrements each cycle while nonzero; PReady=1 for exactly one cycle, starting the cycle after the counter reaches 0 (WAIT_STATES=0: PReady=1 in the first ACCESS cycle, i.e. zero-wait APB).
REQ-019 Writes commit to memory on the edge ending the PReady=1 cycle; exactly one write per transfer.
REQ-020 Reads load PRData on the same edge that raises PReady; PRData holds its value until the next read completion.
REQ-021 After the PReady cycle: PSel=1 and PEnable=0 -> SETUP (back-to-back, no idle cycle needed); otherwise IDLE.
REQ-022 PSel=0 in ACCESS before PReady aborts: -> IDLE, no write, PRData unchanged.
REQ-023 Address in range when PAddr < DEPTH; out-of-range handling per REQ-027/REQ-028.
REQ-024 Minimum transfer latency is 2 cycles (SETUP + ACCESS) plus WAIT_STATES.

Reset
REQ-025 Rst=0 forces, asynchronously: state IDLE, counter 0, PReady=0, PSlvErr=0, PRData=0.
REQ-026 Memory contents are not cleared by reset; an in-flight write aborted by reset does not commit.

Configuration
REQ-027 With APB_MEM_SLVERR_EN defined: out-of-range transfer completes normally in timing, with PSlvErr=1 in the PReady cycle; no write; PRData loaded with 0.
REQ-028 Without APB_MEM_SLVERR_EN: PSlvErr is tied 0; address is taken modulo DEPTH (low clog2(DEPTH) bits) and the transfer proceeds as in range.

Structure
REQ-029 Package apb_mem_pkg holds the state enum type apb_state_e and default width constants APB_ADDR_W=16, APB_DATA_W=32.
REQ-030 Storage is a sub-module apb_mem_array (DEPTH x DATA_W, one synchronous write port, one read port); FSM, counter and outputs stay in apb_mem_slave.

Verification
REQ-031 WAIT_STATES=0: write 0x50 to 0x0050, then read 0x0050 -> PReady high in each first ACCESS cycle, PRData=0x00000050, PSlvErr=0.
REQ-032 WAIT_STATES=2: read -> PReady=0 for 2 ACCESS cycles, high on the 3rd, for one cycle only.
REQ-033 Back-to-back writes 0xA5A5A5A5@0x10 and 0x5A5A5A5A@0x11 with no idle cycle -> both read back correctly.
REQ-034 DEPTH=256, write 0xDEADBEEF to 0x0105: with macro -> PSlvErr=1, memory[0x05] unchanged; without macro -> memory[0x05]=0xDEADBEEF.
REQ-035 WAIT_STATES=3, Rst=0 asserted mid-ACCESS of a write to 0x20 -> PReady=0 immediately, memory[0x20] keeps its old value, next transfer completes normally.
REQ-036 PSel=1 with PEnable=1 in IDLE (no SETUP) -> PReady stays 0, no write.
